// File: rtl/pkt_stream_source_if.sv
// Signal bundle between the ingress word source, pkt_stream_source and the
// header creator that consumes whole packets.
interface pkt_stream_source_if #(
    parameter int BUS_W = 32,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Handshake: ingress is valid-only; in_ready_o is advisory and a word
    // presented while storage is full is dropped together with its packet.
    // Egress: packet_read_req_i is sampled only while idle; once
    // start_of_packet_o fires, the packet streams one word per cycle with
    // no stalls until pkt_eop_o.
    logic             in_valid_i;
    logic             in_sop_i;
    logic             in_eop_i;
    logic [BUS_W-1:0] in_data_i;
    logic             in_ready_o;
    logic             packet_read_req_i;
    logic             start_of_packet_o;
    logic [BUS_W-1:0] packet_bus_o;
    logic             pkt_valid_o;
    logic             pkt_eop_o;
    logic [15:0]      packet_id_o;
    logic [CW-1:0]    pkt_count_o;
    logic             drop_o;
    logic [1:0]       fsm_state;
    logic             wr_in_pkt;

    modport master (
        input  in_valid_i, in_sop_i, in_eop_i, in_data_i, packet_read_req_i,
        output in_ready_o, start_of_packet_o, packet_bus_o, pkt_valid_o,
               pkt_eop_o, packet_id_o, pkt_count_o, drop_o, fsm_state, wr_in_pkt
    );

    modport slave (
        output in_valid_i, in_sop_i, in_eop_i, in_data_i, packet_read_req_i,
        input  in_ready_o, start_of_packet_o, packet_bus_o, pkt_valid_o,
               pkt_eop_o, packet_id_o, pkt_count_o, drop_o, fsm_state, wr_in_pkt
    );
endinterface

// File: rtl/pkt_stream_source.sv
// Store-and-forward packet buffer: commits only complete packets, then
// replays each one behind a start strobe tagged with a 16-bit sequence ID.
module pkt_stream_source #(
    parameter int BUS_W = 32,
    parameter int DEPTH = 16
) (
    input logic                 CLK,
    input logic                 reset,
    pkt_stream_source_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SOP    = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   wr_commit;
    logic [PW-1:0]   pkt_count;
    logic [15:0]     id_ctr;
    logic [15:0]     id_out;
    logic            in_pkt;
    logic            drop;
    logic [BUS_W:0]  mem [DEPTH];

    logic            full;
    logic            take;
    logic            wr_en;
    logic            commit;
    logic            start;
    logic [PW-1:0]   wr_addr;
    logic [BUS_W:0]  rd_word;

    // No bypass: a read in the same cycle does not free space for a write.
    assign full    = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign take    = bus.in_valid_i && (bus.in_sop_i || in_pkt);
    assign wr_addr = bus.in_sop_i ? wr_commit : wr_ptr;
    assign wr_en   = take && !full;
    assign commit  = wr_en && bus.in_eop_i;
    assign start   = (state == IDLE) && bus.packet_read_req_i && (pkt_count != '0);
    assign rd_word = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr[AW-1:0]] <= {bus.in_eop_i, bus.in_data_i};
        end
    end

    // A sop always restarts at wr_commit, silently abandoning a partial packet.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
            in_pkt    <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= take && full;
            if (take && full) begin
                wr_ptr <= wr_commit;
                in_pkt <= 1'b0;
            end else if (wr_en) begin
                wr_ptr <= wr_addr + PW'(1);
                if (bus.in_eop_i) begin
                    wr_commit <= wr_addr + PW'(1);
                    in_pkt    <= 1'b0;
                end else begin
                    in_pkt <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else begin
            case ({commit, start})
                2'b10:   pkt_count <= pkt_count + PW'(1);
                2'b01:   pkt_count <= pkt_count - PW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SOP;
            SOP:     state_nxt = STREAM;
            STREAM:  if (rd_word[BUS_W]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The ID is latched on entry to SOP so it is already valid during the strobe.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            id_ctr <= '0;
            id_out <= '0;
        end else begin
            if (state == STREAM) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (start) begin
                id_out <= id_ctr;
                id_ctr <= id_ctr + 16'd1;
            end
        end
    end

    always_comb begin
        bus.start_of_packet_o = 1'b0;
        bus.pkt_valid_o       = 1'b0;
        bus.pkt_eop_o         = 1'b0;
        bus.packet_bus_o      = '0;
        case (state)
            SOP: bus.start_of_packet_o = 1'b1;
            STREAM: begin
                bus.pkt_valid_o  = 1'b1;
                bus.pkt_eop_o    = rd_word[BUS_W];
                bus.packet_bus_o = rd_word[BUS_W-1:0];
            end
            default: ;
        endcase
    end

    assign bus.in_ready_o  = !full;
    assign bus.packet_id_o = id_out;
    assign bus.pkt_count_o = pkt_count;
    assign bus.drop_o      = drop;
    assign bus.fsm_state   = state;
    assign bus.wr_in_pkt   = in_pkt;
endmodule

// File: tb/tb_pkt_stream_source.sv
// Directed bench for pkt_stream_source: one task per scenario, inline checks.
module tb_pkt_stream_source;
    localparam int BUS_W = 32;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [BUS_W-1:0] exp_q[$];
    logic [BUS_W-1:0] obs_q[$];
    logic             obs_eop_q[$];

    pkt_stream_source_if #(.BUS_W(BUS_W), .DEPTH(DEPTH)) bus ();

    pkt_stream_source #(.BUS_W(BUS_W), .DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic sop, input logic eop, input logic [BUS_W-1:0] data,
                             output logic dropped);
        bus.in_valid_i = 1'b1;
        bus.in_sop_i   = sop;
        bus.in_eop_i   = eop;
        bus.in_data_i  = data;
        step();
        dropped        = bus.drop_o;
        bus.in_valid_i = 1'b0;
        bus.in_sop_i   = 1'b0;
        bus.in_eop_i   = 1'b0;
        bus.in_data_i  = '0;
    endtask

    task automatic send_pkt(input logic [BUS_W-1:0] base, input int n, output int drops);
        logic d;
        drops = 0;
        for (int i = 0; i < n; i++) begin
            send_word(i == 0, i == n - 1, base + BUS_W'(i), d);
            if (d) drops++;
        end
    endtask

    // Raises the request, waits for the strobe, then collects one packet into obs_q.
    task automatic request_pkt(input logic hold, output int lat, output logic [15:0] id,
                               output logic [4:0] cnt_at_sop, output logic quiet,
                               output logic err);
        logic done;
        obs_q.delete();
        obs_eop_q.delete();
        bus.packet_read_req_i = 1'b1;
        lat  = 0;
        err  = 1'b0;
        done = 1'b0;
        id   = '0;
        cnt_at_sop = '0;
        quiet = 1'b0;
        while (bus.start_of_packet_o !== 1'b1 && lat < 4) begin
            step();
            lat++;
        end
        if (bus.start_of_packet_o !== 1'b1) begin
            bus.packet_read_req_i = 1'b0;
            err = 1'b1;
            return;
        end
        id         = bus.packet_id_o;
        cnt_at_sop = bus.pkt_count_o;
        quiet      = (bus.pkt_valid_o === 1'b0) && (bus.packet_bus_o === '0);
        if (!hold) bus.packet_read_req_i = 1'b0;
        for (int k = 0; k < DEPTH && !done; k++) begin
            step();
            if (bus.pkt_valid_o !== 1'b1) begin
                err  = 1'b1;
                done = 1'b1;
            end else begin
                obs_q.push_back(bus.packet_bus_o);
                obs_eop_q.push_back(bus.pkt_eop_o);
                if (bus.pkt_eop_o === 1'b1) done = 1'b1;
            end
        end
        if (!done) err = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.pkt_valid_o !== 1'b0 || bus.start_of_packet_o !== 1'b0 || bus.pkt_eop_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got valid=%b sop=%b eop=%b expected 0 0 0",
                     bus.pkt_valid_o, bus.start_of_packet_o, bus.pkt_eop_o);
        end
        checks++;
        if (bus.packet_bus_o !== '0 || bus.packet_id_o !== 16'h0 || bus.drop_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got bus=%0h id=%0h drop=%b expected 0 0 0",
                     bus.packet_bus_o, bus.packet_id_o, bus.drop_o);
        end
        checks++;
        if (bus.in_ready_o !== 1'b1 || bus.pkt_count_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_ready_count: got ready=%b count=%0d expected 1 0",
                     bus.in_ready_o, bus.pkt_count_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int d; int lat; logic [15:0] id; logic [4:0] c; logic q; logic err;
        send_pkt(32'hA0, 3, d);
        checks++;
        if (bus.pkt_count_o !== 5'd1 || d != 0) begin
            errors++;
            $display("FAIL basic_commit: got count=%0d drops=%0d expected 1 0", bus.pkt_count_o, d);
        end
        exp_q = '{32'hA0, 32'hA1, 32'hA2};
        request_pkt(1'b0, lat, id, c, q, err);
        checks++;
        if (err || lat != 1 || id !== 16'h0000 || c !== 5'd0 || !q) begin
            errors++;
            $display("FAIL basic_sop: got err=%b lat=%0d id=%0h count=%0d quiet=%b expected 0 1 0 0 1",
                     err, lat, id, c, q);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_eop_q[i] !== (i == exp_q.size() - 1)) begin
                errors++;
                $display("FAIL basic_word%0d: got %0h eop=%b expected %0h eop=%b",
                         i, obs_q[i], obs_eop_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic dd; int d; int lat; logic [15:0] id; logic [4:0] c; logic q; logic err;
        send_word(1'b1, 1'b1, 32'h11, dd);
        send_pkt(32'h22, 2, d);
        checks++;
        if (bus.pkt_count_o !== 5'd2) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 2", bus.pkt_count_o);
        end
        request_pkt(1'b1, lat, id, c, q, err);
        checks++;
        if (err || lat != 1 || id !== 16'h0001 || c !== 5'd1 || obs_q.size() != 1) begin
            errors++;
            $display("FAIL b2b_first: got err=%b lat=%0d id=%0h count=%0d len=%0d expected 0 1 1 1 1",
                     err, lat, id, c, obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== 32'h11 || obs_eop_q[0] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_word11: got %0h eop=%b expected 11 eop=1", obs_q[0], obs_eop_q[0]);
            end
        end
        // Request still held: one idle cycle must separate the packets.
        exp_q = '{32'h22, 32'h23};
        request_pkt(1'b0, lat, id, c, q, err);
        checks++;
        if (err || lat != 2 || id !== 16'h0002 || c !== 5'd0) begin
            errors++;
            $display("FAIL b2b_second: got err=%b lat=%0d id=%0h count=%0d expected 0 2 2 0",
                     err, lat, id, c);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_eop_q[i] !== (i == exp_q.size() - 1)) begin
                errors++;
                $display("FAIL b2b_word%0d: got %0h eop=%b expected %0h", i, obs_q[i], obs_eop_q[i], exp_q[i]);
            end
        end
        step();
    endtask

    task automatic test_overflow();
        logic dd; int d; int lat; logic [15:0] id; logic [4:0] c; logic q; logic err;
        send_pkt(32'h100, 10, d);
        checks++;
        if (d != 0 || bus.pkt_count_o !== 5'd1) begin
            errors++;
            $display("FAIL ovf_first: got drops=%0d count=%0d expected 0 1", d, bus.pkt_count_o);
        end
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                checks++;
                if (bus.in_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_ready: got %b expected 0", bus.in_ready_o);
                end
            end
            send_word(i == 0, i == 6, 32'h200 + BUS_W'(i), dd);
            checks++;
            if (dd !== (i == 6)) begin
                errors++;
                $display("FAIL ovf_drop%0d: got %b expected %b", i, dd, i == 6);
            end
        end
        checks++;
        if (bus.pkt_count_o !== 5'd1) begin
            errors++;
            $display("FAIL ovf_count: got %0d expected 1", bus.pkt_count_o);
        end
        step();
        checks++;
        if (bus.drop_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drop_pulse: got %b expected 0", bus.drop_o);
        end
        send_pkt(32'h300, 6, d);
        checks++;
        if (d != 0 || bus.pkt_count_o !== 5'd2) begin
            errors++;
            $display("FAIL ovf_refill: got drops=%0d count=%0d expected 0 2", d, bus.pkt_count_o);
        end
        for (int p = 0; p < 2; p++) begin
            exp_q.delete();
            for (int i = 0; i < (p == 0 ? 10 : 6); i++) exp_q.push_back((p == 0 ? 32'h100 : 32'h300) + BUS_W'(i));
            request_pkt(1'b0, lat, id, c, q, err);
            checks++;
            if (err || lat != 1 || id !== 16'(3 + p) || obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL ovf_pkt%0d: got err=%b lat=%0d id=%0h len=%0d expected 0 1 %0h %0d",
                         p, err, lat, id, obs_q.size(), 3 + p, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i] || obs_eop_q[i] !== (i == exp_q.size() - 1)) begin
                    errors++;
                    $display("FAIL ovf_pkt%0d_word%0d: got %0h eop=%b expected %0h",
                             p, i, obs_q[i], obs_eop_q[i], exp_q[i]);
                end
            end
            step();
        end
    endtask

    task automatic test_abandon();
        logic d0; logic d1; logic d2; int lat; logic [15:0] id; logic [4:0] c; logic q; logic err;
        send_word(1'b1, 1'b0, 32'h51, d0);
        send_word(1'b0, 1'b0, 32'h52, d1);
        send_word(1'b1, 1'b1, 32'h55, d2);
        checks++;
        if ({d0, d1, d2} !== 3'b000 || bus.pkt_count_o !== 5'd1) begin
            errors++;
            $display("FAIL abandon_commit: got drops=%b count=%0d expected 000 1", {d0, d1, d2}, bus.pkt_count_o);
        end
        request_pkt(1'b0, lat, id, c, q, err);
        checks++;
        if (err || id !== 16'h0005 || obs_q.size() != 1) begin
            errors++;
            $display("FAIL abandon_pkt: got err=%b id=%0h len=%0d expected 0 5 1", err, id, obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== 32'h55 || obs_eop_q[0] !== 1'b1) begin
                errors++;
                $display("FAIL abandon_word: got %0h eop=%b expected 55 eop=1", obs_q[0], obs_eop_q[0]);
            end
        end
        step();
        checks++;
        if (bus.pkt_count_o !== 5'd0) begin
            errors++;
            $display("FAIL abandon_count: got %0d expected 0", bus.pkt_count_o);
        end
    endtask

    task automatic test_id_wrap();
        logic dd; int lat; logic [15:0] id; logic [4:0] c; logic q; logic err;
        force dut.id_ctr = 16'hFFFF;
        step();
        release dut.id_ctr;
        send_word(1'b1, 1'b1, 32'h61, dd);
        send_word(1'b1, 1'b1, 32'h62, dd);
        request_pkt(1'b0, lat, id, c, q, err);
        checks++;
        if (err || id !== 16'hFFFF || obs_q.size() != 1 || obs_q[0] !== 32'h61) begin
            errors++;
            $display("FAIL wrap_ffff: got err=%b id=%0h expected 0 ffff", err, id);
        end
        step();
        request_pkt(1'b0, lat, id, c, q, err);
        checks++;
        if (err || id !== 16'h0000 || obs_q.size() != 1 || obs_q[0] !== 32'h62) begin
            errors++;
            $display("FAIL wrap_0000: got err=%b id=%0h expected 0 0", err, id);
        end
        step();
    endtask

    task automatic test_async_reset();
        int d; int lat; logic [15:0] id; logic [4:0] c; logic q; logic err;
        send_pkt(32'h71, 3, d);
        send_pkt(32'h81, 2, d);
        bus.packet_read_req_i = 1'b1;
        step();
        bus.packet_read_req_i = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.pkt_valid_o !== 1'b0 || bus.start_of_packet_o !== 1'b0 || bus.packet_bus_o !== '0 ||
            bus.pkt_eop_o !== 1'b0 || bus.packet_id_o !== 16'h0) begin
            errors++;
            $display("FAIL areset_outputs: got valid=%b sop=%b bus=%0h eop=%b id=%0h expected all 0",
                     bus.pkt_valid_o, bus.start_of_packet_o, bus.packet_bus_o, bus.pkt_eop_o, bus.packet_id_o);
        end
        checks++;
        if (bus.in_ready_o !== 1'b1 || bus.pkt_count_o !== 5'd0 || bus.drop_o !== 1'b0) begin
            errors++;
            $display("FAIL areset_state: got ready=%b count=%0d drop=%b expected 1 0 0",
                     bus.in_ready_o, bus.pkt_count_o, bus.drop_o);
        end
        step();
        rst = 1'b0;
        step();
        send_pkt(32'h91, 1, d);
        checks++;
        if (bus.pkt_count_o !== 5'd1) begin
            errors++;
            $display("FAIL areset_recount: got %0d expected 1", bus.pkt_count_o);
        end
        request_pkt(1'b0, lat, id, c, q, err);
        checks++;
        if (err || lat != 1 || id !== 16'h0000 || obs_q.size() != 1 || obs_q[0] !== 32'h91) begin
            errors++;
            $display("FAIL areset_next_pkt: got err=%b lat=%0d id=%0h len=%0d expected 0 1 0 1",
                     err, lat, id, obs_q.size());
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.in_valid_i        = 1'b0;
        bus.in_sop_i          = 1'b0;
        bus.in_eop_i          = 1'b0;
        bus.in_data_i         = '0;
        bus.packet_read_req_i = 1'b0;
        step();
        step();
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_abandon();
        test_id_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pkt_stream_source.md
Name: pkt_stream_source

Overview:
- Packet store-and-forward buffer that sits directly upstream of the N3-to-N6 header creator.
- Accepts packet words from the ingress side and commits only complete packets.
- On packet_read_req_i it emits a one-cycle start_of_packet_o strobe, then streams the stored words of one packet onto packet_bus_o.
- Tags each emitted packet with a 16-bit sequence ID. Drops packets that do not fit.

Parameters:
- BUS_W, 32, data bus width in bits (matches the header creator bus width).
- DEPTH, 16, word storage entries; power of 2, at least 2.

Ports:
- CLK  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  ingress word valid.
- in_sop_i  in  1  ingress word is the first word of a packet.
- in_eop_i  in  1  ingress word is the last word of a packet.
- in_data_i  in  BUS_W  ingress word.
- in_ready_o  out  1  advisory: storage not full (registered pointers).
- packet_read_req_i  in  1  downstream ready for the next packet.
- start_of_packet_o  out  1  one-cycle packet-start strobe.
- packet_bus_o  out  BUS_W  packet word.
- pkt_valid_o  out  1  packet_bus_o carries a valid word.
- pkt_eop_o  out  1  current word is the last word of the packet.
- packet_id_o  out  16  ID of the packet being emitted.
- pkt_count_o  out  log2(DEPTH)+1  committed packets not yet started.
- drop_o  out  1  one-cycle pulse when a packet is discarded.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears all pointers, pkt_count_o and the ID counter.
  - All outputs are 0; in_ready_o is 1.
  - Egress FSM goes to IDLE. Write side goes to OUT_OF_PKT.
  - A reset mid-packet loses all stored and partial data.
- Storage: DEPTH entries of {eop, data}. Pointers are log2(DEPTH)+1 bits wide.
  - rd_ptr: read pointer.
  - wr_ptr: speculative write pointer.
  - wr_commit: write pointer at the end of the last committed packet.
  - Full when wr_ptr - rd_ptr == DEPTH.
  - No same-cycle read/write bypass of the full condition.
- Write side:
  - A word with in_valid_i=1 and in_sop_i=1 starts a packet. wr_ptr restarts at wr_commit, which silently abandons any unfinished packet (no drop_o).
  - A valid word without sop while OUT_OF_PKT is discarded.
  - Each accepted word is written at wr_ptr, then wr_ptr increments.
  - A word with in_eop_i=1 (sop and eop in the same cycle is allowed) commits the packet: wr_commit <= wr_ptr+1, pkt_count +1, return to OUT_OF_PKT.
  - A valid word arriving while full:
    - word not written; wr_ptr <= wr_commit;
    - drop_o=1 for one cycle;
    - OUT_OF_PKT until the next sop.
  - A packet longer than DEPTH words is always dropped.
- Egress FSM:
  - IDLE: outputs low. If packet_read_req_i=1 and pkt_count>0, go to SOP and decrement pkt_count.
  - SOP (1 cycle):
    - start_of_packet_o=1, packet_bus_o=0, pkt_valid_o=0.
    - packet_id_o takes the ID counter value; the counter then increments, wrapping 0xFFFF->0x0000.
    - Go to STREAM.
  - STREAM: one word per cycle, pkt_valid_o=1, packet_bus_o=mem[rd_ptr], pkt_eop_o=stored eop, rd_ptr increments. On the eop word, go to IDLE.
  - No backpressure inside a packet. packet_read_req_i is sampled only in IDLE.
- Latency:
  - Request in IDLE at cycle t gives start_of_packet_o at t+1 and the first word at t+2.
  - Minimum gap between packets: one IDLE cycle.
- packet_id_o holds its value from SOP until the next SOP.
- Simultaneous commit and egress start in the same cycle: pkt_count is unchanged (+1-1).
- A commit and a drop are never simultaneous, because a full word is never accepted.

Test Plan:
- Reset: assert reset asynchronously mid-stream -> all outputs 0 immediately, in_ready_o=1, pkt_count_o=0; next packet gets ID 0x0000.
- Basic: write 3-word packet {0xA0,0xA1,0xA2}, then read_req=1 -> pkt_count_o=1, then start_of_packet_o one cycle later with packet_id_o=0, then words A0,A1,A2 on consecutive cycles, pkt_eop_o only on A2, pkt_count_o=0.
- Single-word and back-to-back: write {0x11} with sop+eop, then 2-word {0x22,0x23}, read_req held 1 -> SOP,11(eop),IDLE,SOP,22,23(eop); IDs 0 then 1.
- Overflow: DEPTH=16, commit a 10-word packet, then send a 7-word packet -> drop_o pulses on the 7th word, pkt_count_o stays 1, only the 10-word packet is emitted; a following 6-word packet is accepted.
- Abandon: send sop,w1,w2, then a new sop packet {0x55} with eop -> no drop_o, only 0x55 packet emitted.
- ID wrap: preload by passing 65536 packets (or force counter to 0xFFFF) -> packet IDs 0xFFFF then 0x0000.
